// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM encoding and opcode constants for the fetch unit and control.
package fetch_pkg;
   localparam int IW = 21;
   localparam int AW = 6;
   localparam int DEPTH = 64;
   localparam logic [AW-1:0] RESET_PC = '0;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PRIME = 2'd1;
   localparam logic [1:0] RUN = 2'd2;
   localparam logic [1:0] HALT = 2'd3;
   localparam logic [3:0] OP_TERM = 4'b0001;
   localparam logic [3:0] OP_MOD = 4'b1111;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: DEPTH x IW 1W/1R synchronous-read RAM, read-first on address collision.
module instr_mem
   import fetch_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);
   logic [IW-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // Only the read register is cleared; the array keeps the loaded program across resets.
   always_ff @(posedge clk)
      rdata <= rst_n ? mem[raddr] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, instruction memory and IR driven by control's strobes,
// with a host program-load port usable while idle or halted.
module instr_fetch_unit
   import fetch_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          w_pc,
   input  logic          M3,
   input  logic [AW-1:0] gamma,
   input  logic          w_IR,
   input  logic          q,
   output logic [IW-1:0] instruction,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          halted,
   output logic          pc_wrap
);
   logic [1:0] state;
   logic [IW-1:0] rdata;
   logic loadable;
   assign running = state == RUN;
   assign halted = state == HALT;
   assign loadable = state == IDLE || state == HALT;
   instr_mem u_mem (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (prog_we && loadable),
      .waddr(prog_addr),
      .wdata(prog_data),
      .raddr(pc),
      .rdata(rdata)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= RESET_PC;
         instruction <= '0;
         pc_wrap <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT:
               if (start) begin
                  state <= PRIME;
                  pc <= RESET_PC;
                  pc_wrap <= 1'b0;
               end
            PRIME: state <= RUN;
            default:
               // q wins over any strobes issued in the same cycle.
               if (q) state <= HALT;
               else begin
                  if (w_pc) begin
                     pc <= M3 ? pc + 1'b1 : gamma;
                     if (M3 && pc == AW'(DEPTH - 1)) pc_wrap <= 1'b1;
                  end
                  if (w_IR) instruction <= rdata;
               end
         endcase
      end
   end
endmodule
